// File: rtl/se_request_driver.sv
// Host-side request driver for an SE core: FIFO-buffered commands, one outstanding request, latency-tagged responses.
// Optional latency-mismatch detector enabled by defining SE_DRV_LEAK_CHECK_EN.
module se_request_driver #(
  parameter int W       = 128,
  parameter int DEPTH   = 4,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_cmd_valid,
  output logic          io_cmd_ready,
  input  logic [7:0]    io_cmd_inst,
  input  logic [W-1:0]  io_cmd_op1,
  input  logic [W-1:0]  io_cmd_op2,
  input  logic [W-1:0]  io_cmd_cond,
  output logic          io_se_valid,
  input  logic          io_se_ready,
  output logic [7:0]    io_se_inst,
  output logic [W-1:0]  io_se_op1,
  output logic [W-1:0]  io_se_op2,
  output logic [W-1:0]  io_se_cond,
  input  logic [W-1:0]  io_se_result,
  input  logic          io_se_resValid,
  output logic          io_se_resReady,
  output logic          io_rsp_valid,
  input  logic          io_rsp_ready,
  output logic [W-1:0]  io_rsp_result,
  output logic [CW-1:0] io_rsp_latency,
  output logic          io_busy,
  output logic          io_err_timeout,
  output logic [7:0]    io_issued,
  output logic          io_leak
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 8 + 3 * W;
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  logic [EW-1:0] fifo_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          fifo_empty, fifo_full, push, pop;
  logic [EW-1:0] head;

  state_t        state_q;
  logic          se_valid_q, res_ready_q, rsp_valid_q, err_q;
  logic [7:0]    inst_q, issued_q;
  logic [W-1:0]  op1_q, op2_q, cond_q, result_q;
  logic [CW-1:0] cnt_q, cnt_d, lat_q;

`ifdef SE_DRV_LEAK_CHECK_EN
  logic          leak_q, ref_vld_q;
  logic [CW-1:0] ref_lat_q;
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = io_cmd_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= {io_cmd_inst, io_cmd_op1, io_cmd_op2, io_cmd_cond};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      se_valid_q  <= 1'b0;
      res_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      inst_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      cond_q      <= '0;
      result_q    <= '0;
      lat_q       <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
`ifdef SE_DRV_LEAK_CHECK_EN
      leak_q      <= 1'b0;
      ref_vld_q   <= 1'b0;
      ref_lat_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            {inst_q, op1_q, op2_q, cond_q} <= head;
            se_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // Counting starts at 1 so the latency equals edges from request to result handshake.
          if (io_se_ready) begin
            se_valid_q  <= 1'b0;
            res_ready_q <= 1'b1;
            issued_q    <= issued_q + 8'd1;
            cnt_q       <= CNT_ONE;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (io_se_resValid) begin
            res_ready_q <= 1'b0;
            result_q    <= io_se_result;
            lat_q       <= cnt_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
`ifdef SE_DRV_LEAK_CHECK_EN
            if (!ref_vld_q) begin
              ref_vld_q <= 1'b1;
              ref_lat_q <= cnt_q;
            end else if (cnt_q != ref_lat_q) begin
              leak_q <= 1'b1;
            end
`endif
          end else if (cnt_q == CNT_TO) begin
            res_ready_q <= 1'b0;
            err_q       <= 1'b1;
            result_q    <= '0;
            lat_q       <= '1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (io_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_cmd_ready   = !fifo_full;
  assign io_se_valid    = se_valid_q;
  assign io_se_inst     = inst_q;
  assign io_se_op1      = op1_q;
  assign io_se_op2      = op2_q;
  assign io_se_cond     = cond_q;
  assign io_se_resReady = res_ready_q;
  assign io_rsp_valid   = rsp_valid_q;
  assign io_rsp_result  = result_q;
  assign io_rsp_latency = lat_q;
  assign io_busy        = (state_q != IDLE) || !fifo_empty;
  assign io_err_timeout = err_q;
  assign io_issued      = issued_q;
`ifdef SE_DRV_LEAK_CHECK_EN
  assign io_leak        = leak_q;
`else
  assign io_leak        = 1'b0;
`endif

endmodule

// File: tb/tb_se_request_driver.sv
// Directed bench for se_request_driver: table of single-command transactions plus FIFO-full,
// timeout and mid-flight reset sequences.
module tb_se_request_driver;

  localparam int W  = 128;
  localparam int CW = 16;
`ifdef SE_DRV_LEAK_CHECK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  logic          clock, reset;
  logic          io_cmd_valid, io_cmd_ready;
  logic [7:0]    io_cmd_inst;
  logic [W-1:0]  io_cmd_op1, io_cmd_op2, io_cmd_cond;
  logic          io_se_valid, io_se_ready;
  logic [7:0]    io_se_inst;
  logic [W-1:0]  io_se_op1, io_se_op2, io_se_cond;
  logic [W-1:0]  io_se_result;
  logic          io_se_resValid, io_se_resReady;
  logic          io_rsp_valid, io_rsp_ready;
  logic [W-1:0]  io_rsp_result;
  logic [CW-1:0] io_rsp_latency;
  logic          io_busy, io_err_timeout, io_leak;
  logic [7:0]    io_issued;

  int total = 0;
  int bad   = 0;

  se_request_driver #(.W(W), .DEPTH(4), .CW(CW), .TIMEOUT(1024)) dut (
    .clock(clock), .reset(reset),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_inst(io_cmd_inst), .io_cmd_op1(io_cmd_op1), .io_cmd_op2(io_cmd_op2),
    .io_cmd_cond(io_cmd_cond),
    .io_se_valid(io_se_valid), .io_se_ready(io_se_ready),
    .io_se_inst(io_se_inst), .io_se_op1(io_se_op1), .io_se_op2(io_se_op2),
    .io_se_cond(io_se_cond),
    .io_se_result(io_se_result), .io_se_resValid(io_se_resValid),
    .io_se_resReady(io_se_resReady),
    .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready),
    .io_rsp_result(io_rsp_result), .io_rsp_latency(io_rsp_latency),
    .io_busy(io_busy), .io_err_timeout(io_err_timeout),
    .io_issued(io_issued), .io_leak(io_leak)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]   inst;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [W-1:0] cond;
    int           rdy_dly;
    int           res_dly;
    bit           early;
    logic [W-1:0] exp_res;
    logic [CW-1:0] exp_lat;
    bit           exp_leak;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", n, a, e);
    end
  endtask

  task automatic chkw(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic push_cmd(input logic [7:0] inst, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c);
    chk1("cmd_ready_before_push", io_cmd_ready, 1'b1);
    io_cmd_valid = 1'b1;
    io_cmd_inst  = inst;
    io_cmd_op1   = a;
    io_cmd_op2   = b;
    io_cmd_cond  = c;
    tick();
    io_cmd_valid = 1'b0;
    io_cmd_inst  = '0;
    io_cmd_op1   = '0;
    io_cmd_op2   = '0;
    io_cmd_cond  = '0;
  endtask

  task automatic hs_se();
    int n = 0;
    while (io_se_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (io_se_valid !== 1'b1) begin
      bad++;
      $display("FAIL se_valid_wait: got no request within %0d cycles", n);
    end else begin
      io_se_ready = 1'b1;
      tick();
      io_se_ready = 1'b0;
    end
  endtask

  task automatic res_se(input int dly);
    repeat (dly - 1) tick();
    io_se_resValid = 1'b1;
    io_se_result   = io_se_op1 + io_se_op2;
    tick();
    io_se_resValid = 1'b0;
    io_se_result   = '0;
  endtask

  task automatic take_rsp(input string n, input logic [W-1:0] er, input logic [CW-1:0] el);
    int k = 0;
    while (io_rsp_valid !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (io_rsp_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_wait: got no response within %0d cycles", n, k);
    end else begin
      chkw({n, "_result"}, io_rsp_result, er);
      chkw({n, "_latency"}, W'(io_rsp_latency), W'(el));
      io_rsp_ready = 1'b1;
      tick();
      io_rsp_ready = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] fexp [4];
    int n;

    vecs[0] = '{8'h01, 128'd5, 128'd7, 128'd0, 0, 3, 1'b0, 128'd12, 16'd3, 1'b0};
    vecs[1] = '{8'h02, 128'd100, 128'd23, 128'd1, 0, 3, 1'b1, 128'd123, 16'd3, 1'b0};
    vecs[2] = '{8'h03, 128'd1, 128'd1, 128'h7, 10, 5, 1'b0, 128'd2, 16'd5, 1'b1};
    vecs[3] = '{8'hA5, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 128'd1, {W{1'b1}}, 0, 1, 1'b0,
                {64'hFFFF_FFFF_FFFF_FFFF, 64'h1}, 16'd1, 1'b1};
    fexp[0] = 128'd101;
    fexp[1] = 128'd102;
    fexp[2] = 128'd103;
    fexp[3] = 128'd104;

    reset = 1'b0;
    io_cmd_valid = 1'b0; io_cmd_inst = '0; io_cmd_op1 = '0; io_cmd_op2 = '0; io_cmd_cond = '0;
    io_se_ready = 1'b0; io_se_result = '0; io_se_resValid = 1'b0; io_rsp_ready = 1'b0;
    repeat (2) tick();
    chk1("rst_se_valid", io_se_valid, 1'b0);
    chk1("rst_cmd_ready", io_cmd_ready, 1'b1);
    chk1("rst_busy", io_busy, 1'b0);
    chk1("rst_rsp_valid", io_rsp_valid, 1'b0);
    chk1("rst_resReady", io_se_resReady, 1'b0);
    chk1("rst_err", io_err_timeout, 1'b0);
    chk1("rst_leak", io_leak, 1'b0);
    chkw("rst_issued", W'(io_issued), W'(8'd0));
    chkw("rst_rsp_latency", W'(io_rsp_latency), W'(16'd0));
    chkw("rst_rsp_result", io_rsp_result, '0);
    chkw("rst_se_op1", io_se_op1, '0);
    reset = 1'b1;
    tick();

    // Single-command transactions with exact cycle timing.
    for (int i = 0; i < 4; i++) begin
      chk1("v_busy_idle", io_busy, 1'b0);
      push_cmd(vecs[i].inst, vecs[i].op1, vecs[i].op2, vecs[i].cond);
      chk1("v_se_valid_1cyc", io_se_valid, 1'b0);
      chk1("v_busy_pushed", io_busy, 1'b1);
      tick();
      chk1("v_se_valid_2cyc", io_se_valid, 1'b1);
      chkw("v_se_inst", W'(io_se_inst), W'(vecs[i].inst));
      chkw("v_se_op1", io_se_op1, vecs[i].op1);
      chkw("v_se_op2", io_se_op2, vecs[i].op2);
      chkw("v_se_cond", io_se_cond, vecs[i].cond);
      for (int k = 0; k < vecs[i].rdy_dly; k++) begin
        tick();
        chk1("v_se_valid_hold", io_se_valid, 1'b1);
        chkw("v_se_op1_hold", io_se_op1, vecs[i].op1);
        chk1("v_resReady_issue", io_se_resReady, 1'b0);
      end
      io_se_ready = 1'b1;
      if (vecs[i].early) begin
        io_se_resValid = 1'b1;
        io_se_result   = 128'hDEAD;
      end
      tick();
      io_se_ready    = 1'b0;
      io_se_resValid = 1'b0;
      io_se_result   = '0;
      chk1("v_se_valid_drop", io_se_valid, 1'b0);
      chk1("v_resReady_wait", io_se_resReady, 1'b1);
      chk1("v_no_early_rsp", io_rsp_valid, 1'b0);
      repeat (vecs[i].res_dly - 1) tick();
      io_se_resValid = 1'b1;
      io_se_result   = vecs[i].op1 + vecs[i].op2;
      tick();
      io_se_resValid = 1'b0;
      io_se_result   = '0;
      chk1("v_rsp_valid", io_rsp_valid, 1'b1);
      chk1("v_resReady_resp", io_se_resReady, 1'b0);
      chkw("v_rsp_result", io_rsp_result, vecs[i].exp_res);
      chkw("v_rsp_latency", W'(io_rsp_latency), W'(vecs[i].exp_lat));
      chk1("v_leak", io_leak, LEAK_ON & vecs[i].exp_leak);
      tick();
      chk1("v_rsp_hold", io_rsp_valid, 1'b1);
      chkw("v_rsp_result_hold", io_rsp_result, vecs[i].exp_res);
      io_rsp_ready = 1'b1;
      tick();
      io_rsp_ready = 1'b0;
      chk1("v_rsp_done", io_rsp_valid, 1'b0);
      chkw("v_issued", W'(io_issued), W'(i + 1));
    end

    // Fill the FIFO while a response is stalled, then drain in order.
    push_cmd(8'h10, 128'd10, 128'd20, 128'd0);
    hs_se();
    res_se(2);
    chk1("f_stalled_rsp", io_rsp_valid, 1'b1);
    for (int k = 0; k < 4; k++) push_cmd(8'h20 + 8'(k), W'(k + 1), 128'd100, 128'd0);
    chk1("f_full_ready", io_cmd_ready, 1'b0);
    io_cmd_valid = 1'b1;
    io_cmd_inst  = 8'h55;
    io_cmd_op1   = 128'd999;
    tick();
    io_cmd_valid = 1'b0;
    io_cmd_inst  = '0;
    io_cmd_op1   = '0;
    chk1("f_still_full", io_cmd_ready, 1'b0);
    take_rsp("f_first", 128'd30, 16'd2);
    for (int k = 0; k < 4; k++) begin
      hs_se();
      res_se(2);
      take_rsp("f_drain", fexp[k], 16'd2);
    end
    repeat (3) tick();
    chk1("f_no_fifth", io_se_valid, 1'b0);
    chk1("f_idle", io_busy, 1'b0);
    chkw("f_issued", W'(io_issued), W'(8'd9));

    // Result never arrives.
    push_cmd(8'h30, 128'd1, 128'd2, 128'd3);
    hs_se();
    n = 0;
    while (io_rsp_valid !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    chkw("t_cycles", W'(n), W'(1024));
    chkw("t_result", io_rsp_result, '0);
    chkw("t_latency", W'(io_rsp_latency), W'(16'hFFFF));
    chk1("t_err", io_err_timeout, 1'b1);
    io_rsp_ready = 1'b1;
    tick();
    io_rsp_ready = 1'b0;
    push_cmd(8'h31, 128'd4, 128'd4, 128'd0);
    hs_se();
    res_se(2);
    take_rsp("t_after", 128'd8, 16'd2);
    chk1("t_err_sticky", io_err_timeout, 1'b1);
    chkw("t_issued", W'(io_issued), W'(8'd11));

    // Reset while waiting for a result.
    push_cmd(8'h40, 128'd3, 128'd3, 128'd0);
    hs_se();
    repeat (2) tick();
    chk1("r_in_wait", io_se_resReady, 1'b1);
    reset = 1'b0;
    #1;
    chk1("r_resReady", io_se_resReady, 1'b0);
    chk1("r_busy", io_busy, 1'b0);
    chk1("r_err", io_err_timeout, 1'b0);
    chk1("r_leak", io_leak, 1'b0);
    chkw("r_issued", W'(io_issued), W'(8'd0));
    chkw("r_rsp_latency", W'(io_rsp_latency), W'(16'd0));
    chkw("r_rsp_result", io_rsp_result, '0);
    chkw("r_se_op1", io_se_op1, '0);
    tick();
    reset = 1'b1;
    io_se_resValid = 1'b1;
    io_se_result   = 128'hBAD;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("r_no_rsp", io_rsp_valid, 1'b0);
    end
    io_se_resValid = 1'b0;
    io_se_result   = '0;
    push_cmd(8'h41, 128'd20, 128'd22, 128'd0);
    hs_se();
    res_se(3);
    take_rsp("r_next", 128'd42, 16'd3);
    chkw("r_issued_after", W'(io_issued), W'(8'd1));
    chk1("r_leak_after", io_leak, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
